// File: rtl/global_buffer_pkg.sv
// Shared types and widths for the global_buffer processor read path.
package global_buffer_pkg;

  localparam int GLB_ADDR_WIDTH  = 22;
  localparam int BANK_DATA_WIDTH = 64;

  typedef logic [BANK_DATA_WIDTH-1:0] glb_rd_rsp_t;

  // Width of a counter that must hold 0..depth inclusive without wrapping.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/glb_proc_rd_buffer_if.sv
// Host-side read request/response handshake bundle.
interface glb_proc_rd_buffer_if #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 64
) ();

  logic                  host_rd_req_valid;
  logic                  host_rd_req_ready;
  logic [ADDR_WIDTH-1:0] host_rd_req_addr;
  logic                  host_rd_rsp_valid;
  logic                  host_rd_rsp_ready;
  logic [DATA_WIDTH-1:0] host_rd_rsp_data;

  modport master (
    output host_rd_req_valid, host_rd_req_addr, host_rd_rsp_ready,
    input  host_rd_req_ready, host_rd_rsp_valid, host_rd_rsp_data
  );

  modport slave (
    input  host_rd_req_valid, host_rd_req_addr, host_rd_rsp_ready,
    output host_rd_req_ready, host_rd_rsp_valid, host_rd_rsp_data
  );

endinterface

// File: rtl/glb_rd_rsp_fifo.sv
// First-word fall-through response FIFO; head data reads as zero while empty.
module glb_rd_rsp_fifo
  import global_buffer_pkg::*;
#(
  parameter  int DEPTH      = 4,
  parameter  int DATA_WIDTH = BANK_DATA_WIDTH,
  localparam int CW         = cnt_w(DEPTH),
  localparam int PW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CW-1:0]         count_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the read port is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/glb_proc_rd_buffer.sv
// Credit-limited read buffer between the host and global_buffer's processor read port.
module glb_proc_rd_buffer
  import global_buffer_pkg::*;
#(
  parameter  int ADDR_WIDTH = GLB_ADDR_WIDTH,
  parameter  int DATA_WIDTH = BANK_DATA_WIDTH,
  parameter  int DEPTH      = 4,
  localparam int CW         = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  glb_proc_rd_buffer_if.slave   host,
  output logic                  proc_rd_en,
  output logic [ADDR_WIDTH-1:0] proc_rd_addr,
  input  logic [DATA_WIDTH-1:0] proc_rd_data,
  input  logic                  proc_rd_data_valid,
  output logic [CW-1:0]         outstanding,
  output logic                  err_spurious
);

  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  accept, rsp_ok, spurious, pop;
  logic                  proc_rd_en_q;
  logic [ADDR_WIDTH-1:0] proc_rd_addr_q;
  logic                  err_spurious_q;

  // inflight + fifo_count never exceeds DEPTH, so the sum fits in CW bits.
  assign outstanding            = inflight_q + fifo_count;
  assign host.host_rd_req_ready = !reset && (outstanding < CW'(DEPTH));
  assign accept                 = host.host_rd_req_valid && host.host_rd_req_ready;
  assign rsp_ok                 = proc_rd_data_valid && (inflight_q != '0);
  assign spurious               = proc_rd_data_valid && (inflight_q == '0);
  assign host.host_rd_rsp_valid = !fifo_empty;
  assign pop                    = host.host_rd_rsp_valid && host.host_rd_rsp_ready;

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, rsp_ok})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q     <= '0;
      proc_rd_en_q   <= 1'b0;
      proc_rd_addr_q <= '0;
      err_spurious_q <= 1'b0;
    end else begin
      inflight_q   <= inflight_d;
      proc_rd_en_q <= accept;
      if (accept) proc_rd_addr_q <= host.host_rd_req_addr;
      if (spurious) err_spurious_q <= 1'b1;
    end
  end

  assign proc_rd_en   = proc_rd_en_q;
  assign proc_rd_addr = proc_rd_addr_q;
  assign err_spurious = err_spurious_q;

  glb_rd_rsp_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rsp_ok),
    .wdata_i (proc_rd_data),
    .pop_i   (pop),
    .rdata_o (host.host_rd_rsp_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A returning word must always find room; credits make that hold by construction.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset) !(rsp_ok && fifo_full));

endmodule

// File: tb/tb_glb_proc_rd_buffer.sv
// Directed bench: cycle table for single read and credit limit, hand sequences for the rest.
module tb_glb_proc_rd_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        proc_rd_en;
  logic [21:0] proc_rd_addr;
  logic [63:0] proc_rd_data;
  logic        proc_rd_data_valid;
  logic [2:0]  outstanding;
  logic        err_spurious;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  glb_proc_rd_buffer_if #(.ADDR_WIDTH(22), .DATA_WIDTH(64)) host ();

  glb_proc_rd_buffer #(.ADDR_WIDTH(22), .DATA_WIDTH(64), .DEPTH(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .host               (host),
    .proc_rd_en         (proc_rd_en),
    .proc_rd_addr       (proc_rd_addr),
    .proc_rd_data       (proc_rd_data),
    .proc_rd_data_valid (proc_rd_data_valid),
    .outstanding        (outstanding),
    .err_spurious       (err_spurious)
  );

  typedef struct {
    logic        req_v;
    logic [21:0] addr;
    logic        rsp_rdy;
    logic        dv;
    logic [63:0] data;
    logic        e_ready;
    logic        e_rsp_v;
    logic [63:0] e_rsp_data;
    logic        e_en;
    logic [21:0] e_addr;
    logic [2:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic req_v, logic [21:0] addr, logic rsp_rdy, logic dv,
                              logic [63:0] data, logic e_ready, logic e_rsp_v,
                              logic [63:0] e_rsp_data, logic e_en, logic [21:0] e_addr,
                              logic [2:0] e_out, logic e_err);
    vec_t v;
    v.req_v = req_v; v.addr = addr; v.rsp_rdy = rsp_rdy; v.dv = dv; v.data = data;
    v.e_ready = e_ready; v.e_rsp_v = e_rsp_v; v.e_rsp_data = e_rsp_data;
    v.e_en = e_en; v.e_addr = e_addr; v.e_out = e_out; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic req_v, input logic [21:0] addr, input logic rsp_rdy,
                       input logic dv, input logic [63:0] data);
    host.host_rd_req_valid = req_v;
    host.host_rd_req_addr  = addr;
    host.host_rd_rsp_ready = rsp_rdy;
    proc_rd_data_valid     = dv;
    proc_rd_data           = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    #1;
    check("rst_req_ready", host.host_rd_req_ready, 0);
    tick();
    check("rst_rsp_valid", host.host_rd_rsp_valid, 0);
    check("rst_rsp_data", host.host_rd_rsp_data, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err_spurious, 0);
    check("rst_en", proc_rd_en, 0);
    check("rst_addr", proc_rd_addr, 0);
    reset = 1'b0;
  endtask

  initial begin
    logic        pv0, pv1;
    logic [63:0] pd0, pd1;
    int          issued, got;

    vecs[0]  = mk(0, 22'h000, 0, 0, 64'h0, 1, 0, 64'h0, 0, 22'h000, 0, 0);
    vecs[1]  = mk(1, 22'h100, 0, 0, 64'h0, 1, 0, 64'h0, 0, 22'h000, 0, 0);
    vecs[2]  = mk(0, 22'h000, 0, 0, 64'h0, 1, 0, 64'h0, 1, 22'h100, 1, 0);
    vecs[3]  = mk(0, 22'h000, 0, 0, 64'h0, 1, 0, 64'h0, 0, 22'h100, 1, 0);
    vecs[4]  = mk(0, 22'h000, 0, 1, 64'hDEAD_BEEF_0000_0001, 1, 0, 64'h0, 0, 22'h100, 1, 0);
    vecs[5]  = mk(0, 22'h000, 1, 0, 64'h0, 1, 1, 64'hDEAD_BEEF_0000_0001, 0, 22'h100, 1, 0);
    vecs[6]  = mk(0, 22'h000, 0, 0, 64'h0, 1, 0, 64'h0, 0, 22'h100, 0, 0);
    vecs[7]  = mk(1, 22'h200, 0, 0, 64'h0, 1, 0, 64'h0, 0, 22'h100, 0, 0);
    vecs[8]  = mk(1, 22'h208, 0, 0, 64'h0, 1, 0, 64'h0, 1, 22'h200, 1, 0);
    vecs[9]  = mk(1, 22'h210, 0, 0, 64'h0, 1, 0, 64'h0, 1, 22'h208, 2, 0);
    vecs[10] = mk(1, 22'h218, 0, 0, 64'h0, 1, 0, 64'h0, 1, 22'h210, 3, 0);
    vecs[11] = mk(1, 22'h220, 0, 0, 64'h0, 0, 0, 64'h0, 1, 22'h218, 4, 0);
    vecs[12] = mk(1, 22'h228, 0, 0, 64'h0, 0, 0, 64'h0, 0, 22'h218, 4, 0);
    vecs[13] = mk(0, 22'h000, 0, 1, 64'hA0, 0, 0, 64'h0, 0, 22'h218, 4, 0);
    vecs[14] = mk(0, 22'h000, 0, 1, 64'hA1, 0, 1, 64'hA0, 0, 22'h218, 4, 0);
    vecs[15] = mk(0, 22'h000, 0, 1, 64'hA2, 0, 1, 64'hA0, 0, 22'h218, 4, 0);
    vecs[16] = mk(0, 22'h000, 0, 1, 64'hA3, 0, 1, 64'hA0, 0, 22'h218, 4, 0);
    vecs[17] = mk(0, 22'h000, 1, 0, 64'h0, 0, 1, 64'hA0, 0, 22'h218, 4, 0);
    vecs[18] = mk(0, 22'h000, 0, 0, 64'h0, 1, 1, 64'hA1, 0, 22'h218, 3, 0);

    do_reset();

    // single read and credit limit, one row per clock
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].req_v, vecs[i].addr, vecs[i].rsp_rdy, vecs[i].dv, vecs[i].data);
      #1;
      check($sformatf("v%0d_req_ready", i), host.host_rd_req_ready, vecs[i].e_ready);
      check($sformatf("v%0d_rsp_valid", i), host.host_rd_rsp_valid, vecs[i].e_rsp_v);
      check($sformatf("v%0d_rsp_data", i), host.host_rd_rsp_data, vecs[i].e_rsp_data);
      check($sformatf("v%0d_proc_en", i), proc_rd_en, vecs[i].e_en);
      check($sformatf("v%0d_proc_addr", i), proc_rd_addr, vecs[i].e_addr);
      check($sformatf("v%0d_outstanding", i), outstanding, vecs[i].e_out);
      check($sformatf("v%0d_err", i), err_spurious, vecs[i].e_err);
      tick();
    end

    for (int k = 1; k < 4; k++) begin
      drive(0, 0, 1, 0, 0);
      #1;
      check($sformatf("drain%0d_data", k), host.host_rd_rsp_data, 64'hA0 + 64'(k));
      tick();
    end
    drive(0, 0, 0, 0, 0);
    #1;
    check("drain_outstanding", outstanding, 0);

    // streaming through a 2-cycle global_buffer model
    do_reset();
    pv0 = 0; pv1 = 0; pd0 = 0; pd1 = 0; issued = 0; got = 0;
    for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
      drive(issued < 16, 22'(issued * 8), 1, pv1, pd1);
      #1;
      if (host.host_rd_rsp_valid) begin
        check($sformatf("stream%0d_data", got), host.host_rd_rsp_data, 64'(got * 8));
        got++;
      end
      if (host.host_rd_req_valid && host.host_rd_req_ready) issued++;
      pv1 = pv0; pd1 = pd0;
      pv0 = proc_rd_en; pd0 = 64'(proc_rd_addr);
      tick();
    end
    check("stream_count", 64'(got), 64'd16);
    check("stream_err", err_spurious, 0);

    // issue, return and pop in one cycle with fifo_count=2, inflight=1
    do_reset();
    drive(1, 22'hC0, 0, 0, 0);    tick();
    drive(1, 22'hC8, 0, 0, 0);    tick();
    drive(1, 22'hD0, 0, 0, 0);    tick();
    drive(0, 0, 0, 1, 64'h1111);  tick();
    drive(0, 0, 0, 1, 64'h2222);  tick();
    drive(0, 0, 0, 0, 0);
    #1;
    check("simul_pre_outstanding", outstanding, 3);
    drive(1, 22'hD8, 1, 1, 64'h3333);
    #1;
    check("simul_ready", host.host_rd_req_ready, 1);
    check("simul_head0", host.host_rd_rsp_data, 64'h1111);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    check("simul_post_outstanding", outstanding, 3);
    check("simul_en", proc_rd_en, 1);
    check("simul_addr", proc_rd_addr, 22'hD8);
    drive(0, 0, 1, 1, 64'h4444);
    #1;
    check("simul_head1", host.host_rd_rsp_data, 64'h2222);
    tick();
    drive(0, 0, 1, 0, 0);
    #1;
    check("simul_head2", host.host_rd_rsp_data, 64'h3333);
    tick();
    #1;
    check("simul_head3", host.host_rd_rsp_data, 64'h4444);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    check("simul_empty", host.host_rd_rsp_valid, 0);
    check("simul_final_outstanding", outstanding, 0);

    // spurious response with nothing in flight
    do_reset();
    drive(0, 0, 1, 1, 64'h5555);
    #1;
    check("spur_err_before", err_spurious, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    #1;
    check("spur_err", err_spurious, 1);
    check("spur_rsp_valid", host.host_rd_rsp_valid, 0);
    check("spur_outstanding", outstanding, 0);
    repeat (3) tick();
    check("spur_err_sticky", err_spurious, 1);
    do_reset();
    check("spur_err_cleared", err_spurious, 0);

    // reset with three reads outstanding
    drive(1, 22'h280, 0, 0, 0); tick();
    drive(1, 22'h288, 0, 0, 0); tick();
    drive(1, 22'h290, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    #1;
    check("midrst_pre_outstanding", outstanding, 3);
    reset = 1'b1;
    #1;
    check("midrst_ready_in_reset", host.host_rd_req_ready, 0);
    tick();
    reset = 1'b0;
    check("midrst_outstanding", outstanding, 0);
    check("midrst_en", proc_rd_en, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 1, 64'h6660 + 64'(k));
      #1;
      check($sformatf("midrst_late%0d_rsp_valid", k), host.host_rd_rsp_valid, 0);
      tick();
    end
    drive(0, 0, 1, 0, 0);
    #1;
    check("midrst_err", err_spurious, 1);
    check("midrst_rsp_valid", host.host_rd_rsp_valid, 0);
    check("midrst_outstanding_after", outstanding, 0);
    drive(1, 22'h300, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    #1;
    check("fresh_en", proc_rd_en, 1);
    check("fresh_addr", proc_rd_addr, 22'h300);
    tick();
    drive(0, 0, 0, 1, 64'h7777); tick();
    drive(0, 0, 1, 0, 0);
    #1;
    check("fresh_rsp_valid", host.host_rd_rsp_valid, 1);
    check("fresh_rsp_data", host.host_rd_rsp_data, 64'h7777);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    check("fresh_outstanding", outstanding, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/glb_proc_rd_buffer.md
Name: glb_proc_rd_buffer

Overview:
- Sits directly downstream of global_buffer on the processor read path, on the host side.
- Accepts host read requests (valid/ready) and issues them as proc_rd_en/proc_rd_addr pulses.
- Captures proc_rd_data/proc_rd_data_valid into a response FIFO and returns data to the host with valid/ready backpressure.
- Credit accounting guarantees no returning word is ever dropped, whatever the global_buffer read latency.

Parameters:
- ADDR_WIDTH, 22, width of the GLB byte address (matches GLB_ADDR_WIDTH).
- DATA_WIDTH, 64, width of the read data word (matches BANK_DATA_WIDTH).
- DEPTH, 4, response FIFO entries; also the maximum number of outstanding reads. Must be a power of two and at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- host_rd_req_valid  in  1  host read request valid
- host_rd_req_ready  out  1  request accepted when valid&&ready
- host_rd_req_addr  in  ADDR_WIDTH  request address
- host_rd_rsp_valid  out  1  response data valid
- host_rd_rsp_ready  in  1  host can take response
- host_rd_rsp_data  out  DATA_WIDTH  response data
- proc_rd_en  out  1  read strobe to global_buffer
- proc_rd_addr  out  ADDR_WIDTH  read address to global_buffer
- proc_rd_data  in  DATA_WIDTH  read data from global_buffer
- proc_rd_data_valid  in  1  read data valid from global_buffer
- outstanding  out  $clog2(DEPTH+1)  inflight + fifo_count, for debug
- err_spurious  out  1  sticky: response arrived with nothing in flight

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. It clears inflight, fifo_count, the FIFO pointers, proc_rd_en, proc_rd_addr and err_spurious.
- Reset values of outputs: host_rd_req_ready=0 while reset is high, host_rd_rsp_valid=0, host_rd_rsp_data=0, proc_rd_en=0, proc_rd_addr=0, outstanding=0, err_spurious=0.
- Counters are $clog2(DEPTH+1) bits wide and are never allowed to wrap.
  - inflight: reads issued whose data has not yet returned.
  - fifo_count: entries held in the FIFO.
- Request side:
  - host_rd_req_ready = !reset && (inflight + fifo_count < DEPTH). Computed combinationally from registered counters only; it does not depend on host_rd_rsp_ready.
  - On accept, proc_rd_en and proc_rd_addr are registered and driven on the next cycle: 1-cycle issue latency, a 1-cycle pulse per request.
  - Back-to-back accepts give back-to-back pulses.
  - proc_rd_addr holds its last value when proc_rd_en=0.
- inflight update:
  - Increments on the accept cycle.
  - Decrements on a proc_rd_data_valid that is not spurious.
  - Both in the same cycle: no change.
- Response capture:
  - proc_rd_data_valid && inflight>0 writes proc_rd_data at the write pointer.
  - Credits guarantee the FIFO is never full when a write arrives.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- Spurious response (proc_rd_data_valid with inflight==0): data is dropped, err_spurious is set and stays set until reset, and no counter changes.
- Response output:
  - FIFO is first-word fall-through: host_rd_rsp_valid = fifo_count>0, host_rd_rsp_data = head entry.
  - Latency from proc_rd_data_valid to host_rd_rsp_valid is 1 cycle; there is no bypass.
  - A pop occurs on valid&&ready. A push and a pop in the same cycle leave fifo_count unchanged.
- Credit return: a pop frees a credit, and host_rd_req_ready rises the cycle after the pop.
- Ordering: responses are returned strictly in request order. global_buffer returns reads in order.
- Reset mid-operation: everything is cleared, including inflight. Data still returning from global_buffer after reset is counted as spurious and dropped.

Decomposition:
- Shared package global_buffer_pkg: reuse GLB_ADDR_WIDTH and BANK_DATA_WIDTH from global_buffer_param as the parameter defaults. Add typedef glb_rd_rsp_t (DATA_WIDTH data word).
- Sub-module glb_rd_rsp_fifo: parameterised DEPTH, synchronous FWFT FIFO with push, pop, full, empty, count.
- The top level holds the credit/inflight logic and the request register.

Test Plan:
- Single read, 2-cycle GLB latency: request addr 0x100 → proc_rd_en pulse with addr 0x100 one cycle later. Data 0xDEAD_BEEF_0000_0001 returns → host_rd_rsp_valid the next cycle with that data. outstanding goes 1→1→0 after the pop.
- Credit limit: rsp_ready=0, 6 back-to-back requests → exactly 4 accepted. host_rd_req_ready=0 once outstanding=4. Popping one entry re-raises ready the following cycle.
- Streaming: rsp_ready=1, 16 consecutive requests at addresses 0x0, 0x8 … 0x78, data = address → 16 responses in order, matching data, no bubbles beyond latency. Covers pointer wrap four times.
- Simultaneous events: issue, return and pop all in one cycle with fifo_count=2, inflight=1 → counts unchanged, data order preserved.
- Spurious response: proc_rd_data_valid with nothing outstanding → err_spurious=1 and stays set, FIFO stays empty. reset clears err_spurious to 0.
- Reset mid-operation: 3 reads outstanding, assert reset for 1 cycle, then the 3 responses arrive → rsp_valid stays 0, err_spurious=1, and a fresh request after reset completes normally.
